conv_frame_scheduler: RTL and testbench

//  Frame-level sequencer for the 3x3 convolution pipeline. It loads the 9 filter coefficients,

---
 rtl/conv_frame_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_conv_frame_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler
//   Frame-level sequencer for the 3x3 convolution pipeline. Loads the nine
//   filter coefficients, then meters an NxN pixel stream into the line
//   buffers over a valid/ready handshake. It tracks the row/column of each
//   accepted pixel, flags pixels that complete a 3x3 window, and pulses
//   frame_done once the last pixel of a frame has been written.
//
// Parameters
//   N      image width = height in pixels (N >= 3)
//   PIX_W  pixel / coefficient width in bits
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   start        begin a frame (only looked at in IDLE)
//   coeff_valid / coeff_in / coeff_ready   coefficient byte handshake
//   pix_valid / pix_ready                  pixel handshake
//   out_stall    downstream backpressure, blocks pixel acceptance
//   lb_wr_en     line-buffer write strobe (pixel accepted this cycle)
//   row, col     position of the pixel accepted this cycle
//   win_valid    accepted pixel completes a 3x3 window
//   filter       active coefficients, first byte loaded in the MSBs
//   busy         sequencer not idle
//   frame_done   one-cycle pulse following the last pixel of a frame
//
// Build option
//   COEFF_DBUF_EN  adds a shadow coefficient bank that can be filled while a
//                  frame runs; a start with a full shadow bank swaps it into
//                  filter and goes straight to RUN.

module conv_frame_scheduler #(
    parameter int N     = 32,
    parameter int PIX_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          coeff_valid,
    input  logic [PIX_W-1:0]              coeff_in,
    output logic                          coeff_ready,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic                          out_stall,
    output logic                          lb_wr_en,
    output logic [$clog2(N)-1:0]          row,
    output logic [$clog2(N)-1:0]          col,
    output logic                          win_valid,
    output logic [9*PIX_W-1:0]            filter,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int RC_W = $clog2(N);
    localparam int FW   = 9 * PIX_W;

    localparam logic [RC_W-1:0] LAST_IDX = RC_W'(N - 1);
    localparam logic [RC_W-1:0] WIN_MIN  = RC_W'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOADC = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_reg,  state_next;
    logic [RC_W-1:0] row_reg,    row_next;
    logic [RC_W-1:0] col_reg,    col_next;
    logic [FW-1:0]   filter_reg, filter_next;
    logic [3:0]      ccnt_reg,   ccnt_next;

`ifdef COEFF_DBUF_EN
    logic [FW-1:0]   shadow_reg, shadow_next;
    logic [FW-1:0]   shadow_shifted;
    logic            coeff_accept;
`endif

    logic pix_accept;
    logic last_pix;

    // Pixel handshake: only RUN accepts, and only while downstream is not stalled.
    assign pix_accept = (state_reg == RUN) && pix_valid && !out_stall;
    assign last_pix   = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

    assign pix_ready  = (state_reg == RUN) && !out_stall;
    assign lb_wr_en   = pix_accept;
    assign win_valid  = pix_accept && (row_reg >= WIN_MIN) && (col_reg >= WIN_MIN);
    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == DONE);
    assign row        = row_reg;
    assign col        = col_reg;
    assign filter     = filter_reg;

`ifdef COEFF_DBUF_EN
    // The shadow bank accepts bytes in every state until it holds nine.
    assign coeff_ready    = (ccnt_reg < 4'd9);
    assign coeff_accept   = coeff_valid && coeff_ready;
    assign shadow_shifted = {shadow_reg[FW-PIX_W-1:0], coeff_in};
`else
    assign coeff_ready    = (state_reg == LOADC);
`endif

    always_comb begin
        state_next  = state_reg;
        row_next    = row_reg;
        col_next    = col_reg;
        filter_next = filter_reg;
        ccnt_next   = ccnt_reg;
`ifdef COEFF_DBUF_EN
        shadow_next = shadow_reg;
        if (coeff_accept) begin
            shadow_next = shadow_shifted;
            ccnt_next   = ccnt_reg + 4'd1;
        end
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
`ifdef COEFF_DBUF_EN
                    // A full shadow bank means the next filter is ready: skip loading.
                    if (ccnt_reg == 4'd9) begin
                        filter_next = shadow_reg;
                        ccnt_next   = 4'd0;
                        state_next  = RUN;
                    end else begin
                        state_next  = LOADC;
                    end
`else
                    state_next = LOADC;
`endif
                end
            end

            LOADC: begin
`ifdef COEFF_DBUF_EN
                // Transfer on the ninth byte; the count can also already be nine
                // if the bank filled on the same cycle start was taken in IDLE.
                if (coeff_accept && (ccnt_reg == 4'd8)) begin
                    filter_next = shadow_shifted;
                    ccnt_next   = 4'd0;
                    state_next  = RUN;
                end else if (ccnt_reg == 4'd9) begin
                    filter_next = shadow_reg;
                    ccnt_next   = 4'd0;
                    state_next  = RUN;
                end
`else
                if (coeff_valid) begin
                    filter_next = {filter_reg[FW-PIX_W-1:0], coeff_in};
                    if (ccnt_reg == 4'd8) begin
                        ccnt_next  = 4'd0;
                        state_next = RUN;
                    end else begin
                        ccnt_next  = ccnt_reg + 4'd1;
                    end
                end
`endif
            end

            RUN: begin
                if (pix_accept) begin
                    if (last_pix) begin
                        row_next   = '0;
                        col_next   = '0;
                        state_next = DONE;
                    end else if (col_reg == LAST_IDX) begin
                        col_next = '0;
                        row_next = row_reg + RC_W'(1);
                    end else begin
                        col_next = col_reg + RC_W'(1);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            row_reg    <= '0;
            col_reg    <= '0;
            filter_reg <= '0;
            ccnt_reg   <= '0;
`ifdef COEFF_DBUF_EN
            shadow_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            row_reg    <= row_next;
            col_reg    <= col_next;
            filter_reg <= filter_next;
            ccnt_reg   <= ccnt_next;
`ifdef COEFF_DBUF_EN
            shadow_reg <= shadow_next;
`endif
        end
    end

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// tb_conv_frame_scheduler
//   Cycle-driven bench for conv_frame_scheduler (N=4, PIX_W=8). Each cycle the
//   inputs are applied, every output is compared with a behavioural model that
//   tracks the frame as "pixels accepted so far" and the filter as "the last
//   nine bytes loaded", then the model advances across the clock edge.
//   Directed frames come first, then a long randomized run.

module tb_conv_frame_scheduler;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int RC = $clog2(N);

    localparam int M_IDLE  = 0;
    localparam int M_LOADC = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst, start, coeff_valid, pix_valid, out_stall;
    logic [PW-1:0]     coeff_in;
    logic              coeff_ready, pix_ready, lb_wr_en, win_valid, busy, frame_done;
    logic [RC-1:0]     row, col;
    logic [9*PW-1:0]   filter;

    always #5 clk = ~clk;

    conv_frame_scheduler #(.N(N), .PIX_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .coeff_valid (coeff_valid),
        .coeff_in    (coeff_in),
        .coeff_ready (coeff_ready),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .out_stall   (out_stall),
        .lb_wr_en    (lb_wr_en),
        .row         (row),
        .col         (col),
        .win_valid   (win_valid),
        .filter      (filter),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_mode;
    int          m_k;            // pixels accepted in the current frame
    int          m_lcnt;         // coefficients taken in the current load
    logic [7:0]  m_hist [9];     // last nine bytes shifted into filter
    logic [7:0]  m_sh   [9];     // last nine bytes shifted into the shadow bank
    int          m_shcnt;
    logic [71:0] m_filter;

    // Observed per-frame DUT activity
    int d_acc, d_win, frames;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] pack9(input logic [7:0] a [9]);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r = (r << 8) | 72'(a[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_k      = 0;
        m_lcnt   = 0;
        m_shcnt  = 0;
        m_filter = '0;
        for (int i = 0; i < 9; i++) begin
            m_hist[i] = 8'h00;
            m_sh[i]   = 8'h00;
        end
        d_acc = 0;
        d_win = 0;
    endtask

    // One clock cycle: drive, compare, advance the model, cross the edge.
    task automatic cycle(input logic r, input logic s, input logic cv,
                         input logic [7:0] cb, input logic pv, input logic st);
        logic e_cr, e_pr, e_wr, e_win;
        int   e_row, e_col;
        rst = r; start = s; coeff_valid = cv; coeff_in = cb; pix_valid = pv; out_stall = st;
        #3;
        e_row = m_k / N;
        e_col = m_k % N;
`ifdef COEFF_DBUF_EN
        e_cr  = (m_shcnt < 9);
`else
        e_cr  = (m_mode == M_LOADC);
`endif
        e_pr  = (m_mode == M_RUN) && !st;
        e_wr  = e_pr && pv;
        e_win = e_wr && (e_row >= 2) && (e_col >= 2);

        if (!r) begin
            check("busy",        busy,        m_mode != M_IDLE);
            check("coeff_ready", coeff_ready, e_cr);
            check("pix_ready",   pix_ready,   e_pr);
            check("lb_wr_en",    lb_wr_en,    e_wr);
            check("win_valid",   win_valid,   e_win);
            check("frame_done",  frame_done,  m_mode == M_DONE);
            check("row",         row,         e_row);
            check("col",         col,         e_col);
            check("filter",      filter,      m_filter);
            if (frame_done) begin
                check("frame_accepts", d_acc, N * N);
                check("frame_windows", d_win, (N - 2) * (N - 2));
                d_acc = 0;
                d_win = 0;
                frames++;
            end
            if (lb_wr_en)  d_acc++;
            if (win_valid) d_win++;
        end

        if (r) begin
            model_reset();
        end else begin
`ifdef COEFF_DBUF_EN
            begin
                logic full_before;
                full_before = (m_shcnt == 9);
                if (cv && m_shcnt < 9) begin
                    for (int i = 0; i < 8; i++) m_sh[i] = m_sh[i+1];
                    m_sh[8] = cb;
                    m_shcnt++;
                end
                if (m_mode == M_IDLE && s) begin
                    if (full_before) begin
                        m_filter = pack9(m_sh);
                        m_shcnt  = 0;
                        m_mode   = M_RUN;
                    end else begin
                        m_mode   = M_LOADC;
                    end
                end else if (m_mode == M_LOADC) begin
                    if (m_shcnt == 9) begin
                        m_filter = pack9(m_sh);
                        m_shcnt  = 0;
                        m_mode   = M_RUN;
                    end
                end
            end
`else
            if (m_mode == M_IDLE && s) begin
                m_mode = M_LOADC;
            end else if (m_mode == M_LOADC && cv) begin
                for (int i = 0; i < 8; i++) m_hist[i] = m_hist[i+1];
                m_hist[8] = cb;
                m_filter  = pack9(m_hist);
                m_lcnt++;
                if (m_lcnt == 9) begin
                    m_lcnt = 0;
                    m_mode = M_RUN;
                end
            end
`endif
            if (m_mode == M_RUN && e_wr) begin
                m_k++;
                if (m_k == N * N) begin
                    m_k    = 0;
                    m_mode = M_DONE;
                end
            end else if (m_mode == M_DONE) begin
                m_mode = M_IDLE;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic load_coeffs(input logic [7:0] base);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, base + 8'(i), 1'b0, 1'b0);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_mode == M_RUN && m_k != target && guard < 100) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
    endtask

    task automatic finish_frame();
        int guard;
        guard = 0;
        while (m_mode != M_IDLE && guard < 100) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; coeff_valid = 1'b0; coeff_in = '0;
        pix_valid = 1'b0; out_stall = 1'b0;
        frames = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle_cycles(2);

        // Coefficient load 0x01..0x09, then an unstalled frame
        load_coeffs(8'h01);
        check("t2_filter", filter, 72'h010203040506070809);
        check("t2_busy",   busy,   1'b1);
        finish_frame();
        idle_cycles(2);

        // Stall for five cycles at pixel (1,3)
        load_coeffs(8'h31);
        run_to(7);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("t4_row_held", row, 2'd1);
        check("t4_col_held", col, 2'd3);
        finish_frame();
        idle_cycles(1);

        // Reset at pixel (2,1), then a clean frame with new coefficients
        load_coeffs(8'h41);
        run_to(9);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle_cycles(1);
        check("t5_filter_cleared", filter, 72'h0);
        load_coeffs(8'h21);
        check("t5_filter", filter, 72'h212223242526272829);
        check("t5_row0",   row,    2'd0);
        check("t5_col0",   col,    2'd0);
        finish_frame();
        idle_cycles(1);

`ifdef COEFF_DBUF_EN
        // Fill the shadow bank during a frame; filter must not move until the next start
        load_coeffs(8'h01);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, 8'h11 + 8'(i), 1'b1, 1'b0);
        check("t6_filter_frame1", filter, 72'h010203040506070809);
        finish_frame();
        idle_cycles(1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t6_filter_swap", filter, 72'h111213141516171819);
        check("t6_pix_ready",   pix_ready, 1'b1);
        finish_frame();
        idle_cycles(1);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 500) == 0,
                  ($urandom % 6) == 0,
                  1'($urandom % 2),
                  8'($urandom),
                  ($urandom % 4) != 0,
                  ($urandom % 4) == 0);
        end

        check("frames_seen", frames >= 10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
